// File: rtl/svc_vga_pix.sv
// VGA capture: locks to hsync/vsync using runtime timing inputs and emits only visible pixels as a stream.
// Define SVC_VGA_PIX_COORD_EN to add m_pix_x/m_pix_y coordinate outputs.
module svc_vga_pix #(
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12,
  parameter int COLOR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vga_hsync,
  input  logic                   vga_vsync,
  input  logic [COLOR_WIDTH-1:0] vga_red,
  input  logic [COLOR_WIDTH-1:0] vga_grn,
  input  logic [COLOR_WIDTH-1:0] vga_blu,
  input  logic [H_WIDTH-1:0]     h_visible,
  input  logic [H_WIDTH-1:0]     h_sync_start,
  input  logic [H_WIDTH-1:0]     h_sync_end,
  input  logic [H_WIDTH-1:0]     h_line_end,
  input  logic [V_WIDTH-1:0]     v_visible,
  input  logic [V_WIDTH-1:0]     v_sync_start,
  input  logic [V_WIDTH-1:0]     v_sync_end,
  input  logic [V_WIDTH-1:0]     v_frame_end,
  output logic                   m_pix_valid,
  output logic [COLOR_WIDTH-1:0] m_pix_red,
  output logic [COLOR_WIDTH-1:0] m_pix_grn,
  output logic [COLOR_WIDTH-1:0] m_pix_blu,
  output logic                   m_pix_first,
  output logic                   m_pix_last,
  input  logic                   m_pix_ready,
  output logic                   locked,
  output logic                   lock_error,
  output logic                   overflow
`ifdef SVC_VGA_PIX_COORD_EN
  ,
  output logic [H_WIDTH-1:0]     m_pix_x,
  output logic [V_WIDTH-1:0]     m_pix_y
`endif
);

  localparam logic [H_WIDTH-1:0] H_ONE = 1;
  localparam logic [V_WIDTH-1:0] V_ONE = 1;

  typedef enum logic [1:0] {SEARCH, ARMED, LOCKED} state_t;

  state_t                 state, state_next;
  logic                   hs_q, vs_q, hs_d;
  logic [COLOR_WIDTH-1:0] red_q, grn_q, blu_q;
  logic [H_WIDTH-1:0]     h_cnt, cur_h, h_next;
  logic [V_WIDTH-1:0]     v_cnt, cur_v, v_next;
  logic                   exp_hs, exp_vs, mismatch, visible, load, drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs_d  <= 1'b1;
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      hs_q  <= vga_hsync;
      vs_q  <= vga_vsync;
      hs_d  <= hs_q;
      red_q <= vga_red;
      grn_q <= vga_grn;
      blu_q <= vga_blu;
    end
  end

  assign exp_hs = !((h_cnt >= h_sync_start) && (h_cnt < h_sync_end));
  assign exp_vs = !((v_cnt >= v_sync_start) && (v_cnt < v_sync_end));

  // cur_h/cur_v is the position of the sample in stage 1; ARMED overrides it at sync edges.
  always_comb begin
    state_next = state;
    mismatch   = 1'b0;
    visible    = 1'b0;
    cur_h      = h_cnt;
    cur_v      = v_cnt;
    case (state)
      SEARCH: if (!vs_q) state_next = ARMED;
      ARMED: begin
        if (vs_q) begin
          state_next = LOCKED;
          cur_h      = '0;
          cur_v      = v_sync_end;
        end else if (hs_q && !hs_d) begin
          cur_h = h_sync_end;
        end
      end
      LOCKED: begin
        mismatch = (hs_q != exp_hs) || (vs_q != exp_vs);
        if (mismatch) state_next = SEARCH;
        else          visible = (h_cnt < h_visible) && (v_cnt < v_visible);
      end
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    h_next = cur_h + H_ONE;
    v_next = cur_v;
    if (cur_h == h_line_end) begin
      h_next = '0;
      v_next = (cur_v == v_frame_end) ? '0 : cur_v + V_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEARCH;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next == SEARCH) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else begin
        h_cnt <= h_next;
        v_cnt <= v_next;
      end
    end
  end

  assign load = visible && (!m_pix_valid || m_pix_ready);
  assign drop = visible && !load;

  // Single-entry output slot: a visible sample that finds it occupied and stalled is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_pix_valid <= 1'b0;
      m_pix_red   <= '0;
      m_pix_grn   <= '0;
      m_pix_blu   <= '0;
      m_pix_first <= 1'b0;
      m_pix_last  <= 1'b0;
      locked      <= 1'b0;
      lock_error  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      lock_error <= mismatch;
      locked     <= (state_next == LOCKED);
      if (drop) overflow <= 1'b1;
      if (load) begin
        m_pix_valid <= 1'b1;
        m_pix_red   <= red_q;
        m_pix_grn   <= grn_q;
        m_pix_blu   <= blu_q;
        m_pix_first <= (h_cnt == '0) && (v_cnt == '0);
        m_pix_last  <= (h_cnt == h_visible - H_ONE) && (v_cnt == v_visible - V_ONE);
      end else if (m_pix_ready) begin
        m_pix_valid <= 1'b0;
      end
    end
  end

`ifdef SVC_VGA_PIX_COORD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_pix_x <= '0;
      m_pix_y <= '0;
    end else if (load) begin
      m_pix_x <= h_cnt;
      m_pix_y <= v_cnt;
    end
  end
`else
  // Without coordinates, frame position is conveyed only by m_pix_first/m_pix_last.
`endif

endmodule

// File: tb/tb_svc_vga_pix.sv
// Randomized scoreboard bench for svc_vga_pix: a VGA generator feeds the DUT while a position-level
// model predicts emitted pixels and lock/overflow status; a monitor compares independently.
module tb_svc_vga_pix;

  localparam int HW = 12, VW = 12, CW = 4;
  localparam int HV = 16, HSS = 18, HSE = 22, HLE = 25;
  localparam int VV = 8,  VSS = 9,  VSE = 11, VFE = 12;
  localparam int ARR  = 8192;
  localparam int MAXC = 6000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vga_hsync, vga_vsync;
  logic [CW-1:0] vga_red, vga_grn, vga_blu;
  logic [HW-1:0] h_visible, h_sync_start, h_sync_end, h_line_end;
  logic [VW-1:0] v_visible, v_sync_start, v_sync_end, v_frame_end;
  logic          m_pix_valid, m_pix_first, m_pix_last, m_pix_ready;
  logic [CW-1:0] m_pix_red, m_pix_grn, m_pix_blu;
  logic          locked, lock_error, overflow;
`ifdef SVC_VGA_PIX_COORD_EN
  logic [HW-1:0] m_pix_x;
  logic [VW-1:0] m_pix_y;
`endif

  always #5 clk = ~clk;

  svc_vga_pix #(.H_WIDTH(HW), .V_WIDTH(VW), .COLOR_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu),
    .h_visible(h_visible), .h_sync_start(h_sync_start), .h_sync_end(h_sync_end), .h_line_end(h_line_end),
    .v_visible(v_visible), .v_sync_start(v_sync_start), .v_sync_end(v_sync_end), .v_frame_end(v_frame_end),
    .m_pix_valid(m_pix_valid), .m_pix_red(m_pix_red), .m_pix_grn(m_pix_grn), .m_pix_blu(m_pix_blu),
    .m_pix_first(m_pix_first), .m_pix_last(m_pix_last), .m_pix_ready(m_pix_ready),
    .locked(locked), .lock_error(lock_error), .overflow(overflow)
`ifdef SVC_VGA_PIX_COORD_EN
    , .m_pix_x(m_pix_x), .m_pix_y(m_pix_y)
`endif
  );

  typedef struct { int r; int g; int b; int first; int last; int x; int y; int load_n; } pix_t;
  typedef struct { int h; int v; int hs; int vs; int r; int g; int b; int glitch; } samp_t;

  pix_t exp_q[$];
  bit   exp_known[ARR];
  bit   exp_lk[ARR];
  bit   exp_er[ARR];
  bit   exp_ov[ARR];
  int   n_vec = 0;
  int   n_err = 0;
  int   negn = 0;
  bit   started = 1'b0;
  bit   done = 1'b0;

  task automatic checkOutput(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, negn, act, req);
    end
  endtask

  task automatic applyStimulus(input samp_t s);
    vga_hsync = s.hs[0];
    vga_vsync = s.vs[0];
    vga_red   = CW'(s.r);
    vga_grn   = CW'(s.g);
    vga_blu   = CW'(s.b);
  endtask

  // Generator plus reference model: frame 0 partial, 1 clean, 2 stall burst, 3 random ready,
  // 4 hsync glitch on line 3, 5..6 clean after relock.
  initial begin : gen
    samp_t cur, prev;
    int    gh, gv, frame;
    bit    lk, seen_low, full, ovf, er, loaded, rdy;
    pix_t  p;
    rst_n = 1'b0; m_pix_ready = 1'b1;
    vga_hsync = 1'b1; vga_vsync = 1'b1; vga_red = '0; vga_grn = '0; vga_blu = '0;
    h_visible = HW'(HV); h_sync_start = HW'(HSS); h_sync_end = HW'(HSE); h_line_end = HW'(HLE);
    v_visible = VW'(VV); v_sync_start = VW'(VSS); v_sync_end = VW'(VSE); v_frame_end = VW'(VFE);
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", int'(m_pix_valid), 0);
    checkOutput("reset_locked", int'(locked), 0);
    checkOutput("reset_lock_error", int'(lock_error), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    gh = 7; gv = 5; frame = 0;
    lk = 0; seen_low = 0; full = 0; ovf = 0;
    rst_n = 1'b1;
    started = 1'b1;
    while (!(frame == 6 && gv == VSS && gh == 0) && negn < MAXC) begin
      if (started && negn > 0) begin
        case (frame)
          2:       rdy = !(gv == 2 && (gh == 6 || gh == 7));
          3:       rdy = ($urandom_range(0, 3) != 0);
          default: rdy = 1'b1;
        endcase
        m_pix_ready = rdy;
        // Judge the sample driven last cycle against this cycle's ready.
        er = 0; loaded = 0;
        if (prev.glitch != 0) begin
          lk = 0; er = 1; seen_low = 0;
        end else if (lk) begin
          if (prev.h < HV && prev.v < VV) begin
            if (!full || rdy) begin
              p.r = prev.r; p.g = prev.g; p.b = prev.b;
              p.first = (prev.h == 0 && prev.v == 0);
              p.last  = (prev.h == HV - 1 && prev.v == VV - 1);
              p.x = prev.h; p.y = prev.v; p.load_n = negn + 1;
              exp_q.push_back(p);
              full = 1; loaded = 1;
            end else begin
              ovf = 1;
            end
          end
        end else begin
          if (prev.vs == 0) seen_low = 1;
          else if (seen_low && prev.h == 0 && prev.v == VSE) begin
            lk = 1; seen_low = 0;
          end
        end
        if (!loaded && rdy) full = 0;
        if (negn + 1 < ARR) begin
          exp_known[negn + 1] = 1'b1;
          exp_lk[negn + 1] = lk;
          exp_er[negn + 1] = er;
          exp_ov[negn + 1] = ovf;
        end
      end
      cur.h = gh; cur.v = gv;
      cur.hs = !(gh >= HSS && gh < HSE);
      cur.vs = !(gv >= VSS && gv < VSE);
      cur.glitch = (frame == 4 && gv == 3 && gh == HSS - 1);
      if (cur.glitch != 0) cur.hs = 0;
      cur.r = $urandom_range(0, 15); cur.g = $urandom_range(0, 15); cur.b = $urandom_range(0, 15);
      applyStimulus(cur);
      prev = cur;
      if (gh == HLE) begin
        gh = 0;
        gv = (gv == VFE) ? 0 : gv + 1;
        if (gv == 0) frame++;
      end else begin
        gh++;
      end
      @(negedge clk);
      negn++;
    end
    checkOutput("frames_completed", frame, 6);
    done = 1'b1;
    m_pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Monitor: status flags each cycle, pixels popped from the scoreboard on each transfer.
  initial begin : mon
    int   m;
    pix_t e;
    wait (started);
    while (!done) begin
      @(negedge clk);
      #1;
      if (done) break;
      m = negn;
      if (m < ARR && exp_known[m]) begin
        checkOutput("locked", int'(locked), int'(exp_lk[m]));
        checkOutput("lock_error", int'(lock_error), int'(exp_er[m]));
        checkOutput("overflow", int'(overflow), int'(exp_ov[m]));
      end
      if (exp_q.size() == 0) begin
        checkOutput("idle_valid", int'(m_pix_valid), 0);
      end else if (exp_q[0].load_n <= m) begin
        checkOutput("latency_valid", int'(m_pix_valid), 1);
      end
      if (m_pix_valid && m_pix_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pix_not_early", int'(m >= e.load_n), 1);
        checkOutput("pix_red", int'(m_pix_red), e.r);
        checkOutput("pix_grn", int'(m_pix_grn), e.g);
        checkOutput("pix_blu", int'(m_pix_blu), e.b);
        checkOutput("pix_first", int'(m_pix_first), e.first);
        checkOutput("pix_last", int'(m_pix_last), e.last);
`ifdef SVC_VGA_PIX_COORD_EN
        checkOutput("pix_x", int'(m_pix_x), e.x);
        checkOutput("pix_y", int'(m_pix_y), e.y);
`endif
      end
    end
  end

endmodule
